// File: rtl/vreg_read_seq_if.sv
// Request and element-stream handshake bundle for the vector register read sequencer.
// The sequencer sits on the slave side; the requester/consumer sits on the master side.
interface vreg_read_seq_if #(
    parameter int IW = 5,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_base;
    logic [IW:0]   req_len;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output req_valid, req_base, req_len, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  req_valid, req_base, req_len, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/vreg_read_seq.sv
// Vector register read sequencer: walks consecutive registers through one
// combinational register file read port and streams them out element by element.
module vreg_read_seq #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    vreg_read_seq_if.slave          bus,
    output logic [$clog2(NREG)-1:0] rf_read_reg,
    input  logic [DW-1:0]           rf_read_data,
    output logic                    busy,
    output logic                    done
);
    localparam int IW = $clog2(NREG);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] MAXLEN = LW'(NREG);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] cur_reg;
    logic [LW-1:0] remaining;
    logic [IW-1:0] elem;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;

    logic [LW-1:0] len_c;
    logic          load;

    assign len_c = (bus.req_len > MAXLEN) ? MAXLEN : bus.req_len;
    // Output slot is free when empty or its beat is leaving this cycle.
    assign load  = !out_valid || bus.out_ready;

    assign bus.req_ready = (state == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;
    assign rf_read_reg   = cur_reg;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_reg   <= '0;
            remaining <= '0;
            elem      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cur_reg   <= bus.req_base;
                        remaining <= len_c;
                        elem      <= '0;
                        if (len_c == '0) done  <= 1'b1;
                        else             state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (load) begin
                        out_data  <= rf_read_data;
                        out_idx   <= elem;
                        out_last  <= (remaining == LW'(1));
                        out_valid <= 1'b1;
                        cur_reg   <= cur_reg + 1'b1;
                        remaining <= remaining - 1'b1;
                        elem      <= elem + 1'b1;
                        if (remaining == LW'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vreg_read_seq.sv
// Self-checking bench for vreg_read_seq: a behavioural register file plus a
// shadow-array model that predicts each request's element stream.
module tb_vreg_read_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vreg_read_seq_if bus();
    logic [4:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic        busy;
    logic        done;

    vreg_read_seq dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .rf_read_reg (rf_read_reg),
        .rf_read_data(rf_read_data),
        .busy        (busy),
        .done        (done)
    );

    // Register file: two write ports, combinational read, r0 reads zero.
    logic [31:0] rf [32];
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    always @(posedge clk) begin
        if (we0) rf[wa0] <= wd0;
        if (we1) rf[wa1] <= wd1;
    end
    assign rf_read_data = (rf_read_reg == 5'd0) ? 32'd0 : rf[rf_read_reg];

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } beat_t;

    logic [31:0] mem [32];
    beat_t       got[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready)
            got.push_back({bus.out_data, bus.out_idx, bus.out_last});

    function automatic logic [31:0] ref_rd(input int r);
        return (r == 0) ? 32'd0 : mem[r];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        we0 = 1'b1; wa0 = a; wd0 = d;
        step();
        we0 = 1'b0;
        mem[a] = d;
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1,1
    task automatic run_req(input string name, input logic [4:0] base,
                           input logic [5:0] len, input int mode, input bit wr);
        int    n;
        int    k;
        int    done_k;
        bit    seen_done;
        bit    prev_stall;
        beat_t prev;
        beat_t exp[$];
        bit    pat[5];
        logic [31:0] wdat;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        n = (len > 6'd32) ? 32 : int'(len);
        for (int e = 0; e < n; e++)
            exp.push_back('{d: ref_rd((int'(base) + e) % 32), i: 5'(e), l: (e == n - 1)});
        got.delete();
        bus.out_ready = 1'b1;
        step();
        bus.req_valid = 1'b1; bus.req_base = base; bus.req_len = len;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready);
        end
        step();
        bus.req_valid = 1'b0;
        if (wr) begin
            wdat = $urandom;
            we0 = 1'b1; wa0 = base; wd0 = wdat;
            we1 = 1'b1; wa1 = base + 5'd1; wd1 = 32'h99;
            mem[base] = wdat;
            mem[base + 5'd1] = 32'h99;
            for (int e = 1; e < n; e++)
                exp[e].d = ref_rd((int'(base) + e) % 32);
        end
        k = 0; done_k = -1; seen_done = 0; prev_stall = 0; prev = '0;
        while (!seen_done && k < 300) begin
            case (mode)
                1:       bus.out_ready = ($urandom % 3) != 0;
                2:       bus.out_ready = (k >= 1 && k <= 5) ? pat[k-1] : 1'b1;
                default: bus.out_ready = 1'b1;
            endcase
            if (n == 0 && k == 0) begin
                n_checks++;
                if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s len0: busy=%b valid=%b done=%b want 0 0 1",
                             name, busy, bus.out_valid, done);
                end
            end
            if (mode == 0 && n > 0 && k < n) begin
                n_checks++;
                if (rf_read_reg !== 5'((int'(base) + k) % 32)) begin
                    n_fail++;
                    $display("FAIL %s rf_read_reg k=%0d: got %0d want %0d",
                             name, k, rf_read_reg, (int'(base) + k) % 32);
                end
            end
            if (mode == 0 && n > 0 && k == 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s latency: valid=%b busy=%b want 0 1",
                             name, bus.out_valid, busy);
                end
            end
            if (mode == 0 && k >= 1 && k <= n) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'(k - 1) || bus.req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s stream k=%0d: valid=%b idx=%0d rdy=%b want 1 %0d 0",
                             name, k, bus.out_valid, bus.out_idx, bus.req_ready, k - 1);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 ||
                    {bus.out_data, bus.out_idx, bus.out_last} !== prev) begin
                    n_fail++;
                    $display("FAIL %s hold k=%0d: got %h/%0d/%b want %h/%0d/%b", name, k,
                             bus.out_data, bus.out_idx, bus.out_last, prev.d, prev.i, prev.l);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                done_k = k;
            end else begin
                prev_stall = bus.out_valid && !bus.out_ready;
                prev = {bus.out_data, bus.out_idx, bus.out_last};
                step();
                k++;
                if (wr && k == 1) begin
                    we0 = 1'b0; we1 = 1'b0;
                end
            end
        end
        if (!seen_done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, k);
        end else begin
            if (mode == 0) begin
                n_checks++;
                if (done_k != ((n == 0) ? 0 : n + 1)) begin
                    n_fail++;
                    $display("FAIL %s done timing: got cycle %0d want %0d",
                             name, done_k, (n == 0) ? 0 : n + 1);
                end
            end
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after done: done=%b busy=%b rdy=%b valid=%b want 0 0 1 0",
                         name, done, busy, bus.req_ready, bus.out_valid);
            end
        end
        n_checks++;
        if (got.size() != n) begin
            n_fail++;
            $display("FAIL %s beat count: got %0d want %0d", name, got.size(), n);
        end
        for (int e = 0; e < n && e < got.size(); e++) begin
            n_checks++;
            if (got[e] !== exp[e]) begin
                n_fail++;
                $display("FAIL %s beat %0d: got %h/%0d/%b want %h/%0d/%b", name, e,
                         got[e].d, got[e].i, got[e].l, exp[e].d, exp[e].i, exp[e].l);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_base = '0; bus.req_len = '0;
        bus.out_ready = 1'b0;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        #2;
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, done, busy} !== '0
            || bus.req_ready !== 1'b1 || rf_read_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h idx=%0d last=%b done=%b busy=%b rdy=%b want zeros rdy=1",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, done, busy, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) rf_write(5'(r), $urandom);
    endtask

    task automatic test_basic();
        rf_write(5'd5, 32'h11); rf_write(5'd6, 32'h22);
        rf_write(5'd7, 32'h33); rf_write(5'd8, 32'h44);
        run_req("basic", 5'd5, 6'd4, 0, 1'b0);
    endtask

    task automatic test_wrap_zero();
        rf_write(5'd30, 32'hA); rf_write(5'd31, 32'hB); rf_write(5'd1, 32'hC);
        run_req("wrap_zero", 5'd30, 6'd4, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_req("backpressure", 5'd2, 6'd3, 2, 1'b0);
    endtask

    task automatic test_edge_len();
        run_req("len0", 5'd9, 6'd0, 0, 1'b0);
        run_req("len40", 5'd17, 6'd40, 0, 1'b0);
        run_req("len32", 5'd0, 6'd32, 1, 1'b0);
    endtask

    task automatic test_coherency();
        rf_write(5'd10, 32'h1010); rf_write(5'd11, 32'h1111);
        run_req("coherency", 5'd10, 6'd2, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_req("b2b_a", 5'd20, 6'd3, 0, 1'b0);
        run_req("b2b_b", 5'd23, 6'd2, 0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b1;
        step();
        bus.req_valid = 1'b1; bus.req_base = 5'd3; bus.req_len = 6'd20;
        step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, done, busy} !== '0
            || bus.req_ready !== 1'b1 || rf_read_reg !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b data=%h idx=%0d last=%b done=%b busy=%b rdy=%b want zeros rdy=1",
                     bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, done, busy, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (bus.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid quiet %0d: valid=%b done=%b busy=%b want 0 0 0",
                         c, bus.out_valid, done, busy);
            end
        end
        got.delete();
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            repeat (3) rf_write(5'($urandom % 32), $urandom);
            run_req("random", 5'($urandom % 32), 6'($urandom_range(0, 40)),
                    int'($urandom % 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_zero();
        test_backpressure();
        test_edge_len();
        test_coherency();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
